// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 VGA raster generator and pin driver.
// A clock divider produces a pixel strobe. Column/line counters advance on
// that strobe, and are published to the pixel generator. The returned
// colour is registered together with the sync of the same pixel, so the
// pins always show pixel (h,v) alongside that pixel's sync levels.
//
// Handshake: there is no valid/ready pair. The colour inputs must
// combinationally describe the pixel at (hcount, vcount). They are sampled
// on every clk edge where pix_tick=1.
module vga_scan_out #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       active,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    // Derived raster totals and region boundaries.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // The divider is at least one bit wide so CLK_DIV=1 still elaborates.
    // In that case it sits at 0, which is also the tick value.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Active and inactive sync pin levels.
    localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Reject parameter sets the 10-bit counters cannot represent.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_err
        $error("vga_scan_out: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic [3:0]       r_red;
    logic [3:0]       r_green;
    logic [3:0]       r_blue;

    logic w_pix_tick;
    logic w_active;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_hs_region;
    logic w_vs_region;

    assign w_pix_tick  = (r_div == DIV_LAST);
    assign w_active    = (r_hcount < H_VIS_END) && (r_vcount < V_VIS_END);
    assign w_h_wrap    = (r_hcount == H_LAST);
    assign w_v_wrap    = (r_vcount == V_LAST);
    assign w_hs_region = (r_hcount >= H_SYNC_FIRST) && (r_hcount <= H_SYNC_LAST);
    assign w_vs_region = (r_vcount >= V_SYNC_FIRST) && (r_vcount <= V_SYNC_LAST);

    // The pixel-rate divider counts 0..CLK_DIV-1. The tick is its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_pix_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // The column/line counters advance once per pixel tick. A column wrap carries into the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_pix_tick) begin
            if (w_h_wrap) begin
                r_hcount <= '0;
                r_vcount <= w_v_wrap ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // Pin registers: sync and colour of the pre-increment pixel, black when blanked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= SYNC_OFF;
            r_vsync <= SYNC_OFF;
            r_red   <= 4'h0;
            r_green <= 4'h0;
            r_blue  <= 4'h0;
        end else if (w_pix_tick) begin
            r_hsync <= w_hs_region ? SYNC_ON : SYNC_OFF;
            r_vsync <= w_vs_region ? SYNC_ON : SYNC_OFF;
            r_red   <= w_active ? red_in   : 4'h0;
            r_green <= w_active ? green_in : 4'h0;
            r_blue  <= w_active ? blue_in  : 4'h0;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign active      = w_active;
    assign pix_tick    = w_pix_tick;
    assign frame_start = w_pix_tick && (r_hcount == 10'd0) && (r_vcount == 10'd0);
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_red;
    assign vga_g       = r_green;
    assign vga_b       = r_blue;

endmodule
